// File: rtl/or_vector_sequencer_if.sv
// Signal bundle between the OR-gate self-test sequencer and its environment.
// The slave side is the sequencer; the master side drives start/abort and feeds back d/e.
interface or_vector_sequencer_if;
  logic       start;
  logic       abort;
  logic       d_in;
  logic       e_in;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [2:0] vec_idx;
  logic [7:0] resp_d;
  logic [7:0] resp_e;

  modport master (
    output start, abort, d_in, e_in,
    input  a, b, c, busy, done, vec_idx, resp_d, resp_e
  );

  modport slave (
    input  start, abort, d_in, e_in,
    output a, b, c, busy, done, vec_idx, resp_d, resp_e
  );
endinterface

// File: rtl/or_vector_sequencer.sv
// Walks {a,b,c} through 000..111, holding each vector DWELL cycles, and captures
// the gate's d/e outputs on the last dwell cycle of every vector.
module or_vector_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  or_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DWELL - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       vec_idx_q;
  logic [7:0]       resp_d_q;
  logic [7:0]       resp_e_q;
  logic             last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort)                          state_d = S_IDLE;
        else if (last_beat && vec_idx_q == 3'd7) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vec_idx_q <= 3'd0;
      resp_d_q  <= 8'd0;
      resp_e_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cnt_q     <= '0;
            vec_idx_q <= 3'd0;
            resp_d_q  <= 8'd0;
            resp_e_q  <= 8'd0;
          end
        end
        S_RUN: begin
          // Abort suppresses the sample even when it lands on the final beat.
          if (!bus.abort) begin
            if (last_beat) begin
              resp_d_q[vec_idx_q] <= bus.d_in;
              resp_e_q[vec_idx_q] <= bus.e_in;
              cnt_q               <= '0;
              if (vec_idx_q != 3'd7) vec_idx_q <= vec_idx_q + 3'd1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign bus.busy              = (state_q == S_RUN);
  assign bus.done              = (state_q == S_DONE);
  assign {bus.a, bus.b, bus.c} = (state_q == S_RUN) ? vec_idx_q : 3'd0;
  assign bus.vec_idx           = vec_idx_q;
  assign bus.resp_d            = resp_d_q;
  assign bus.resp_e            = resp_e_q;

endmodule

// File: tb/tb_or_vector_sequencer.sv
// Self-checking bench: a DWELL=4 and a DWELL=2 sequencer fed by a table-driven gate model.
module tb_or_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pat_d = 8'hFE;
  logic [7:0] pat_e = 8'h01;
  int         errors = 0;
  int         checks = 0;

  or_vector_sequencer_if if4 ();
  or_vector_sequencer_if if2 ();

  // Gate model: response for vector v is bit v of the pattern (FE/01 = ideal OR/NOR).
  assign if4.d_in = pat_d[{if4.a, if4.b, if4.c}];
  assign if4.e_in = pat_e[{if4.a, if4.b, if4.c}];
  assign if2.d_in = pat_d[{if2.a, if2.b, if2.c}];
  assign if2.e_in = pat_e[{if2.a, if2.b, if2.c}];

  or_vector_sequencer #(.DWELL(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  or_vector_sequencer #(.DWELL(2), .CNT_W(8)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({if4.busy, if4.done, if4.a, if4.b, if4.c} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/abc=%b required 00000", {if4.busy, if4.done, if4.a, if4.b, if4.c});
    end
    checks++;
    if ({if4.vec_idx, if4.resp_d, if4.resp_e} !== 19'd0) begin
      errors++;
      $display("FAIL reset_regs: vec_idx=%0d resp_d=%h resp_e=%h required all 0", if4.vec_idx, if4.resp_d, if4.resp_e);
    end
    rst = 1'b0;
    step();
  endtask

  // One complete DWELL=4 run checked cycle by cycle against the timeline.
  task automatic run_full4(input string tag);
    int c_changes = 0;
    int a_changes = 0;
    logic [2:0] prev_abc;
    logic [2:0] exp_abc;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    prev_abc = 3'd0;
    for (int n = 1; n <= 34; n++) begin
      exp_abc = (n <= 32) ? 3'((n - 1) / 4) : 3'd0;
      checks++;
      if (if4.busy !== (n <= 32) || if4.done !== (n == 33)) begin
        errors++;
        $display("FAIL %s_busy_done: cycle %0d busy=%b done=%b required busy=%b done=%b",
                 tag, n, if4.busy, if4.done, n <= 32, n == 33);
      end
      checks++;
      if ({if4.a, if4.b, if4.c} !== exp_abc) begin
        errors++;
        $display("FAIL %s_abc: cycle %0d abc=%b required %b", tag, n, {if4.a, if4.b, if4.c}, exp_abc);
      end
      if (n >= 2 && n <= 32) begin
        if (if4.c !== prev_abc[0]) c_changes++;
        if (if4.a !== prev_abc[2]) a_changes++;
      end
      prev_abc = {if4.a, if4.b, if4.c};
      step();
    end
    checks++;
    if (c_changes != 7 || a_changes != 1) begin
      errors++;
      $display("FAIL %s_toggles: c changed %0d a changed %0d required 7 and 1", tag, c_changes, a_changes);
    end
    checks++;
    if (if4.resp_d !== pat_d || if4.resp_e !== pat_e || if4.vec_idx !== 3'd7) begin
      errors++;
      $display("FAIL %s_resp: resp_d=%h resp_e=%h vec_idx=%0d required %h %h 7",
               tag, if4.resp_d, if4.resp_e, if4.vec_idx, pat_d, pat_e);
    end
  endtask

  task automatic test_full_run();
    pat_d = 8'hFE;
    pat_e = 8'h01;
    repeat (8) step();
    run_full4("ideal");
  endtask

  task automatic test_random_patterns();
    for (int r = 0; r < 3; r++) begin
      pat_d = 8'($urandom);
      pat_e = 8'($urandom);
      run_full4("random");
    end
  endtask

  task automatic test_reset_mid_run();
    pat_d = 8'hFE;
    pat_e = 8'h01;
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || {if4.a, if4.b, if4.c} !== 3'd0 || if4.resp_d !== 8'd0 || if4.vec_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b abc=%b resp_d=%h vec_idx=%0d required 0 000 00 0",
               if4.busy, {if4.a, if4.b, if4.c}, if4.resp_d, if4.vec_idx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle: cycle %0d done=%b busy=%b required 0 0", i, if4.done, if4.busy);
      end
      step();
    end
  endtask

  // Abort during run cycle n: vectors whose sampling edge precedes cycle n are kept.
  task automatic abort_at(input int n);
    int   sampled;
    logic [7:0] mask;
    sampled = (n - 1) / 4;
    mask = 8'((1 << sampled) - 1);
    if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    for (int i = 1; i < n; i++) step();
    if4.abort = 1'b1;
    step();
    if4.abort = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || {if4.a, if4.b, if4.c} !== 3'd0) begin
      errors++;
      $display("FAIL abort%0d_ctrl: busy=%b done=%b abc=%b required 0 0 000",
               n, if4.busy, if4.done, {if4.a, if4.b, if4.c});
    end
    checks++;
    if (if4.resp_d !== (pat_d & mask) || if4.resp_e !== (pat_e & mask) || if4.vec_idx !== 3'(sampled)) begin
      errors++;
      $display("FAIL abort%0d_resp: resp_d=%h resp_e=%h vec_idx=%0d required %h %h %0d",
               n, if4.resp_d, if4.resp_e, if4.vec_idx, pat_d & mask, pat_e & mask, sampled);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if4.done !== 1'b0 || if4.resp_d !== (pat_d & mask)) begin
        errors++;
        $display("FAIL abort%0d_hold: done=%b resp_d=%h required 0 %h", n, if4.done, if4.resp_d, pat_d & mask);
      end
    end
  endtask

  task automatic test_abort();
    pat_d = 8'hFE;
    pat_e = 8'h01;
    abort_at(13);
    abort_at(32);
    pat_d = 8'($urandom);
    pat_e = 8'($urandom);
    abort_at(int'($urandom_range(32, 1)));
  endtask

  task automatic test_start_abort_idle();
    if4.start = 1'b1;
    if4.abort = 1'b1;
    step();
    if4.start = 1'b0;
    if4.abort = 1'b0;
    checks++;
    if (if4.busy !== 1'b1 || {if4.a, if4.b, if4.c} !== 3'd0) begin
      errors++;
      $display("FAIL start_wins: busy=%b abc=%b required 1 000", if4.busy, {if4.a, if4.b, if4.c});
    end
    if4.abort = 1'b1;
    step();
    if4.abort = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int i;
    pat_d = 8'hFE;
    pat_e = 8'h01;
    if4.start = 1'b1;
    step();
    for (int n = 1; n <= 35; n++) begin
      checks++;
      if (if4.busy !== (n <= 32 || n == 35) || if4.done !== (n == 33)) begin
        errors++;
        $display("FAIL b2b_seq: cycle %0d busy=%b done=%b required %b %b",
                 n, if4.busy, if4.done, n <= 32 || n == 35, n == 33);
      end
      if (n < 35) step();
    end
    checks++;
    if (if4.resp_d !== 8'd0 || if4.resp_e !== 8'd0) begin
      errors++;
      $display("FAIL b2b_clear: resp_d=%h resp_e=%h required 00 00", if4.resp_d, if4.resp_e);
    end
    if4.start = 1'b0;
    i = 0;
    while (i < 40 && if4.done !== 1'b1) begin
      step();
      i++;
    end
    checks++;
    if (if4.done !== 1'b1 || i != 32) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b after %0d cycles required 1 after 32", if4.done, i);
    end
    checks++;
    if (if4.resp_d !== 8'hFE || if4.resp_e !== 8'h01) begin
      errors++;
      $display("FAIL b2b_resp: resp_d=%h resp_e=%h required fe 01", if4.resp_d, if4.resp_e);
    end
    step();
  endtask

  task automatic test_stuck_dwell2();
    pat_d = 8'h00;
    pat_e = 8'($urandom);
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      checks++;
      if (if2.busy !== (n <= 16) || if2.done !== (n == 17) ||
          {if2.a, if2.b, if2.c} !== ((n <= 16) ? 3'((n - 1) / 2) : 3'd0)) begin
        errors++;
        $display("FAIL dw2_seq: cycle %0d busy=%b done=%b abc=%b required %b %b %b", n, if2.busy,
                 if2.done, {if2.a, if2.b, if2.c}, n <= 16, n == 17, (n <= 16) ? 3'((n - 1) / 2) : 3'd0);
      end
      step();
    end
    checks++;
    if (if2.resp_d !== 8'h00 || if2.resp_e !== pat_e) begin
      errors++;
      $display("FAIL dw2_resp: resp_d=%h resp_e=%h required 00 %h", if2.resp_d, if2.resp_e, pat_e);
    end
  endtask

  initial begin
    if4.start = 1'b0;
    if4.abort = 1'b0;
    if2.start = 1'b0;
    if2.abort = 1'b0;
    test_reset();
    test_full_run();
    test_random_patterns();
    test_reset_mid_run();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_stuck_dwell2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
